// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calc datapath and its downstream blocks.
//   Q_DWIDTH - width of the result word produced by calc (q_o).
package calc_pkg;

  localparam int unsigned Q_DWIDTH = 16;

endpackage

// File: rtl/calc_result_fifo.sv
// calc_result_fifo: result buffer placed directly downstream of calc.
// Captures every tvalid_i/q_i strobe into a DEPTH-entry FIFO and presents the
// words on a first-word-fall-through valid/ready stream. calc cannot stall, so
// a strobe arriving while full (and not freed by a same-cycle pop) is dropped,
// flagged on overflow_o (sticky) and counted on drop_cnt_o (saturating).
//
// Ports:
//   clk, arst_n     - clock (rising edge), asynchronous active-low reset
//   tvalid_i, q_i   - result strobe and word from calc
//   tvalid_o        - at least one word stored
//   tdata_o         - oldest stored word (valid while tvalid_o)
//   tready_i        - consumer accepts tdata_o this cycle
//   usedw_o         - number of stored words, 0..DEPTH
//   full_o          - usedw_o == DEPTH
//   overflow_o      - sticky: at least one word was dropped since reset
//   drop_cnt_o      - number of dropped words, saturating
module calc_result_fifo #(
  parameter int unsigned DWIDTH    = calc_pkg::Q_DWIDTH,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     tvalid_i,
  input  logic [DWIDTH-1:0]        q_i,
  output logic                     tvalid_o,
  output logic [DWIDTH-1:0]        tdata_o,
  input  logic                     tready_i,
  output logic [$clog2(DEPTH):0]   usedw_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned UW = AW + 1;

  // Pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("calc_result_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [DWIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [UW-1:0]        count;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_cnt;

  logic not_empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // Status decoded from the registered occupancy count.
  assign not_empty = (count != '0);
  assign full      = (count == UW'(DEPTH));

  // A pop in the same cycle frees the slot for an incoming word when full.
  assign pop  = not_empty && tready_i;
  assign push = tvalid_i && (!full || pop);
  assign drop = tvalid_i && full && !pop;

  // Storage array: written on push only, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= q_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + UW'(1);
      end else if (pop && !push) begin
        count <= count - UW'(1);
      end
    end
  end

  // Drop tracking: sticky flag plus saturating counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign tvalid_o   = not_empty;
  assign tdata_o    = mem[rd_ptr];
  assign usedw_o    = count;
  assign full_o     = full;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_calc_result_fifo.sv
// tb_calc_result_fifo: randomized, self-checking bench for calc_result_fifo.
// A queue-based reference model tracks stored words, drops and the sticky flag.
// A second instance with CNT_WIDTH=2 shares all inputs to exercise saturation.
module tb_calc_result_fifo;

  localparam int unsigned DW    = calc_pkg::Q_DWIDTH;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned UW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          arst_n;
  logic          tvalid_i;
  logic [DW-1:0] q_i;
  logic          tready_i;

  logic          tvalid_o;
  logic [DW-1:0] tdata_o;
  logic [UW-1:0] usedw_o;
  logic          full_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [UW-1:0] s_usedw;
  logic          s_full;
  logic          s_overflow;
  logic [1:0]    s_drop_cnt;

  calc_result_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .arst_n(arst_n), .tvalid_i(tvalid_i), .q_i(q_i),
    .tvalid_o(tvalid_o), .tdata_o(tdata_o), .tready_i(tready_i),
    .usedw_o(usedw_o), .full_o(full_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  calc_result_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .arst_n(arst_n), .tvalid_i(tvalid_i), .q_i(q_i),
    .tvalid_o(s_tvalid), .tdata_o(s_tdata), .tready_i(tready_i),
    .usedw_o(s_usedw), .full_o(s_full), .overflow_o(s_overflow),
    .drop_cnt_o(s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_drops = 0;
  bit            m_ovf   = 1'b0;
  logic [DW-1:0] got[$];

  task automatic model_reset();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock: drive inputs, record the word the consumer takes, advance model.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    bit do_pop;
    bit do_push;
    tvalid_i = v;
    q_i      = d;
    tready_i = r;
    do_pop  = (mq.size() != 0) && r;
    do_push = v && ((mq.size() < DEPTH) || do_pop);
    #1;
    if (do_pop) got.push_back(tdata_o);
    @(posedge clk);
    if (do_pop) mq.delete(0);
    if (do_push) mq.push_back(d);
    if (v && !do_push) begin
      m_drops++;
      m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() != 0 && guard < 50) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    n_cmp++;
    if (tvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: tvalid_o=%0b required 0 after %0d cycles", tvalid_o, guard);
    end
  endtask

  task automatic test_power_on();
    n_cmp++;
    if (tvalid_o !== 1'b0 || usedw_o !== '0 || full_o !== 1'b0 ||
        overflow_o !== 1'b0 || drop_cnt_o !== 8'd0 || s_drop_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL power_on: tvalid=%0b usedw=%0d full=%0b ovf=%0b drop=%0d sdrop=%0d required all 0",
               tvalid_o, usedw_o, full_o, overflow_o, drop_cnt_o, s_drop_cnt);
    end
  endtask

  task automatic test_pass_through();
    step(1'b1, DW'(16'h15), 1'b1);
    n_cmp++;
    if (tvalid_o !== 1'b1 || tdata_o !== DW'(16'h15)) begin
      n_err++;
      $display("FAIL pass_first: tvalid=%0b tdata=%0h required 1 / 15", tvalid_o, tdata_o);
    end
    step(1'b0, '0, 1'b1);
    n_cmp++;
    if (tvalid_o !== 1'b0 || usedw_o !== UW'(0)) begin
      n_err++;
      $display("FAIL pass_after: tvalid=%0b usedw=%0d required 0 / 0", tvalid_o, usedw_o);
    end
  endtask

  task automatic test_order_wrap();
    int sent;
    int cyc;
    got.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    n_cmp++;
    if (full_o !== 1'b1 || usedw_o !== UW'(8)) begin
      n_err++;
      $display("FAIL fill8: full=%0b usedw=%0d required 1 / 8", full_o, usedw_o);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== DW'(i + 1)) begin
        n_err++;
        $display("FAIL order_%0d: got %0h required %0h (received %0d words)",
                 i, (i < got.size()) ? got[i] : '0, i + 1, got.size());
      end
    end
    // 12 back-to-back strobes under a 2-on/1-off ready pattern
    got.delete();
    sent = 9;
    cyc  = 0;
    while ((sent <= 20 || mq.size() != 0) && cyc < 100) begin
      if (sent <= 20) begin
        step(1'b1, DW'(sent), (cyc % 3) != 2);
        sent++;
      end else begin
        step(1'b0, '0, (cyc % 3) != 2);
      end
      cyc++;
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== DW'(i + 9)) begin
        n_err++;
        $display("FAIL wrap_%0d: got %0h required %0h (received %0d words)",
                 i, (i < got.size()) ? got[i] : '0, i + 9, got.size());
      end
    end
    n_cmp++;
    if (overflow_o !== 1'b0 || tvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_end: overflow=%0b tvalid=%0b required 0 / 0", overflow_o, tvalid_o);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_w[8];
    got.delete();
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = DW'($urandom);
      step(1'b1, exp_w[i], 1'b0);
    end
    step(1'b1, DW'(16'hA), 1'b0);
    step(1'b1, DW'(16'hB), 1'b0);
    step(1'b1, DW'(16'hC), 1'b0);
    n_cmp++;
    if (drop_cnt_o !== 8'd3 || overflow_o !== 1'b1 || usedw_o !== UW'(8)) begin
      n_err++;
      $display("FAIL overflow: drop=%0d ovf=%0b usedw=%0d required 3 / 1 / 8",
               drop_cnt_o, overflow_o, usedw_o);
    end
    drain();
    n_cmp++;
    if (got.size() != 8) begin
      n_err++;
      $display("FAIL overflow_count: received %0d words required 8", got.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL overflow_data_%0d: got %0h required %0h",
                 i, (i < got.size()) ? got[i] : '0, exp_w[i]);
      end
    end
  endtask

  task automatic test_full_pop();
    got.delete();
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h60 + i), 1'b0);
    step(1'b1, DW'(16'h77), 1'b1);
    n_cmp++;
    if (usedw_o !== UW'(8) || full_o !== 1'b1 || drop_cnt_o !== 8'd3) begin
      n_err++;
      $display("FAIL full_pop: usedw=%0d full=%0b drop=%0d required 8 / 1 / 3",
               usedw_o, full_o, drop_cnt_o);
    end
    drain();
    n_cmp++;
    if (got.size() != 9 || got[got.size() - 1] !== DW'(16'h77)) begin
      n_err++;
      $display("FAIL full_pop_last: received %0d words, last %0h required 9 / 77",
               got.size(), (got.size() != 0) ? got[got.size() - 1] : '0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== DW'(16'h60 + i)) begin
        n_err++;
        $display("FAIL full_pop_data_%0d: got %0h required %0h",
                 i, (i < got.size()) ? got[i] : '0, 16'h60 + i);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0);
    n_cmp++;
    if (drop_cnt_o !== 8'd9 || s_drop_cnt !== 2'd3 || s_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL saturation: drop8=%0d drop2=%0d ovf2=%0b required 9 / 3 / 1",
               drop_cnt_o, s_drop_cnt, s_overflow);
    end
    drain();
  endtask

  task automatic test_random();
    bit            hold;
    logic [DW-1:0] prev;
    bit            v;
    bit            r;
    int            exp_drop;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 5);
      hold = tvalid_o && !r;
      prev = tdata_o;
      step(v, DW'($urandom), r);
      exp_drop = (m_drops > 255) ? 255 : m_drops;
      n_cmp++;
      if (usedw_o !== UW'(mq.size()) || tvalid_o !== (mq.size() != 0) ||
          full_o !== (mq.size() == DEPTH) || overflow_o !== m_ovf ||
          drop_cnt_o !== 8'(exp_drop) ||
          s_drop_cnt !== ((m_drops > 3) ? 2'd3 : 2'(m_drops))) begin
        n_err++;
        $display("FAIL rand_status_%0d: usedw=%0d tvalid=%0b full=%0b ovf=%0b drop=%0d sdrop=%0d required usedw=%0d ovf=%0b drops=%0d",
                 c, usedw_o, tvalid_o, full_o, overflow_o, drop_cnt_o, s_drop_cnt,
                 mq.size(), m_ovf, m_drops);
      end
      if (mq.size() != 0) begin
        n_cmp++;
        if (tdata_o !== mq[0]) begin
          n_err++;
          $display("FAIL rand_data_%0d: tdata=%0h required %0h", c, tdata_o, mq[0]);
        end
      end
      if (hold) begin
        n_cmp++;
        if (tdata_o !== prev) begin
          n_err++;
          $display("FAIL rand_hold_%0d: tdata=%0h required held %0h", c, tdata_o, prev);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
    n_cmp++;
    if (usedw_o !== UW'(3) || overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: usedw=%0d ovf=%0b required 3 / 1", usedw_o, overflow_o);
    end
    // Mid-cycle asynchronous reset with a strobe in flight
    tvalid_i = 1'b1;
    q_i      = DW'(16'h5A);
    tready_i = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (usedw_o !== '0 || tvalid_o !== 1'b0 || full_o !== 1'b0 ||
        overflow_o !== 1'b0 || drop_cnt_o !== 8'd0 || s_drop_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: usedw=%0d tvalid=%0b full=%0b ovf=%0b drop=%0d sdrop=%0d required all 0",
               usedw_o, tvalid_o, full_o, overflow_o, drop_cnt_o, s_drop_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    tvalid_i = 1'b0;
    arst_n   = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (tvalid_o !== 1'b0 || usedw_o !== '0) begin
        n_err++;
        $display("FAIL reset_release_%0d: tvalid=%0b usedw=%0d required 0 / 0", i, tvalid_o, usedw_o);
      end
    end
  endtask

  initial begin
    arst_n   = 1'b0;
    tvalid_i = 1'b0;
    q_i      = '0;
    tready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_power_on();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    test_pass_through();
    test_order_wrap();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_result_fifo.md
# calc_result_fifo

Output buffer placed directly downstream of `calc`. It captures every `tvalid`/`q` result pulse, stores it in a small first-in-first-out buffer, and presents the results on a valid/ready stream so a stalling consumer can drain them. `calc` cannot be back-pressured, so any result that arrives while the buffer is full is dropped. Each drop is flagged and counted.

## Interface
Parameters:
- `DWIDTH`, default `calc_pkg::Q_DWIDTH`: result word width.
- `DEPTH`, default 8: number of stored words. Must be a power of 2 and ≥ 2.
- `CNT_WIDTH`, default 8: width of the drop counter.

Ports:
- `clk`, input, 1: clock. All logic is on the rising edge.
- `arst_n`, input, 1: reset, asynchronous, active-low.
- `tvalid_i`, input, 1: result strobe from `calc` (`tvalid_o`).
- `q_i`, input, DWIDTH: result word from `calc` (`q_o`).
- `tvalid_o`, output, 1: buffer holds at least one word.
- `tdata_o`, output, DWIDTH: oldest stored word. Valid only while `tvalid_o` = 1.
- `tready_i`, input, 1: consumer accepts `tdata_o` this cycle.
- `usedw_o`, output, $clog2(DEPTH)+1: number of stored words, 0..DEPTH.
- `full_o`, output, 1: `usedw_o` == DEPTH.
- `overflow_o`, output, 1: sticky. Set by the first dropped word.
- `drop_cnt_o`, output, CNT_WIDTH: number of dropped words, saturating.

## Operation
- Storage is a DEPTH-entry register array with write and read pointers of $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH.
- Push condition: `push = tvalid_i && (!full_o || pop)`.
- Pop condition: `pop = tvalid_o && tready_i`.
- Push writes `q_i` at the write pointer, then the write pointer increments.
- Pop advances the read pointer.
- `usedw_o` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- `tdata_o` = mem[rd_ptr]. It is a combinational read of registered storage, so the output is first-word-fall-through.
- `tvalid_o` = (`usedw_o` != 0). `full_o` = (`usedw_o` == DEPTH). Both are decoded from the registered count.
- Drop condition: `tvalid_i && full_o && !pop`.
  - The word is discarded; stored contents are unchanged.
  - `overflow_o` is set to 1.
  - `drop_cnt_o` increments and saturates at 2^CNT_WIDTH−1.
- When full, a pop in the same cycle frees the slot, so the incoming word is accepted and not dropped.
- Data that does not satisfy the push condition is ignored: a word is written only when `tvalid_i` = 1 and the push condition holds.
- Holding rule: while `tvalid_o` = 1 and `tready_i` = 0, `tdata_o` must hold stable.
- `tready_i` while empty has no effect.

## Timing
- Reset (`arst_n` low) acts immediately, without waiting for a clock edge, and forces:
  - the read and write pointers to 0;
  - `usedw_o` = 0, `tvalid_o` = 0, `full_o` = 0, `overflow_o` = 0, `drop_cnt_o` = 0.
- The storage array is not reset.
- Reset asserted mid-operation flushes all stored words and discards any in-flight strobe.
- Release of `arst_n` is synchronised externally. The first edge after release may already push.
- Latency: a push on edge N into an empty buffer gives `tvalid_o` = 1 and `tdata_o` = that word in the cycle after edge N.
- Pop on edge N: the next word, if any, appears in the cycle after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `calc` strobes on back-to-back cycles are all captured while space remains.
- `overflow_o` and `drop_cnt_o` update on the same edge as the dropped strobe.
- `overflow_o` clears only on reset.

## Test plan
- **Reset values:** assert `arst_n`=0 mid-cycle with 3 words stored.
  - Outputs go to their reset values immediately (`usedw_o`=0, `tvalid_o`=0, `overflow_o`=0, `drop_cnt_o`=0).
  - After release, `tvalid_o` stays 0.
- **Single pass-through:** `tready_i`=1, one strobe with `q_i`=0x15.
  - Next cycle: `tvalid_o`=1, `tdata_o`=0x15.
  - Following cycle: `tvalid_o`=0, `usedw_o`=0.
- **Ordering and wrap-around:** `tready_i`=0, push 1..8 (DEPTH=8).
  - `full_o`=1, `usedw_o`=8.
  - Raise `tready_i` and drain: outputs 1..8 in order.
  - Repeat with 9..20 (12 words) under a 2-cycle-on/1-off ready pattern: all 12 in order, `overflow_o`=0.
- **Overflow:** fill to 8, hold `tready_i`=0, send 3 more strobes (0xA, 0xB, 0xC).
  - `drop_cnt_o`=3, `overflow_o`=1.
  - Drain yields the original 8 words only.
- **Full with simultaneous pop:** full buffer, `tready_i`=1 and `tvalid_i`=1 with 0x77 on the same edge.
  - `usedw_o` stays 8, no drop.
  - 0x77 is the last word drained.
- **Counter saturation:** CNT_WIDTH=2, full buffer, 6 dropped strobes → `drop_cnt_o`=3.
